vga_scanout: RTL
================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter IMG_W, default 100, meaning image width in pixels (1..640).
REQ-002 SHALL have parameter IMG_H, default 100, meaning image height in lines (1..480).
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning frame-buffer word address of pixel (0,0).
REQ-004 SHALL have parameter S, default 32, meaning address and data word width.
REQ-005 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-006 clk  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 fb_rd_en  output  1  frame-buffer read strobe.
REQ-009 fb_addr  output  S  frame-buffer word address.
REQ-010 fb_rdata  input  S  read data, valid exactly one clk after fb_rd_en; bits [23:0] = {R,G,B}.
REQ-011 rgb  output  24  pixel colour to DAC.
REQ-012 h_sync  output  1  horizontal sync, active low.
REQ-013 v_sync  output  1  vertical sync, active low.
REQ-014 vga_clk  output  1  25 MHz pixel clock.
REQ-015 frame_start  output  1  one-clk pulse when pixel (0,0) is launched.

Function
REQ-016 SHALL keep phase bit ph, toggling every clk; vga_clk = ph; a "pixel edge" is a clk edge where ph==1.
REQ-017 SHALL keep counters h (0..799) and v (0..524), advancing only on pixel edges; h wraps 799->0 and increments v; v wraps 524->0.
REQ-018 Timing 640x480@60: H visible 0..639, front 640..655, sync 656..751, back 752..799; V visible 0..479, front 480..489, sync 490..491, back 492..524.
REQ-019 At each pixel edge SHALL launch the current (h,v): fb_rd_en=1 iff h<IMG_W and v<IMG_H, else 0; fb_rd_en SHALL be 0 on non-pixel edges.
REQ-020 SHALL generate fb_addr from a running address counter, no multiplier: loaded with BASE_ADDR when (0,0) is launched, incremented after every in-image launch; fb_addr = BASE_ADDR + v*IMG_W + h for in-image launches.
REQ-021 After the last image pixel the address counter SHALL hold until the next (0,0) launch; no wrap.
REQ-022 SHALL register fb_rdata[23:0] on the pixel edge following the launch; rgb SHALL present that value when the launched pixel was in-image, 24'h000000 otherwise (incl. all blanking).
REQ-023 h_sync/v_sync SHALL be delayed to match rgb: all three reflect pixel (h,v) from the pixel edge after its launch edge (latency 1 pixel period = 2 clk).
REQ-024 frame_start SHALL be 1 for exactly the clk following the (0,0) launch edge.
REQ-025 fb_rdata[S-1:24] SHALL be ignored.

Reset
REQ-026 While rst=1 at a clk edge: ph=0, h=0, v=0, address counter=BASE_ADDR, fb_rd_en=0, fb_addr=0, rgb=0, h_sync=1, v_sync=1, frame_start=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame; the first pixel edge after release launches (0,0) with frame_start pulse; any read in flight SHALL be discarded (rgb stays 0).

Configuration
REQ-028 Macro VGA_BORDER_EN: when defined, pixels with (h==IMG_W and v<=IMG_H) or (v==IMG_H and h<=IMG_W), within visible area, SHALL output rgb=24'hFFFFFF with fb_rd_en=0.
REQ-029 When VGA_BORDER_EN is undefined those pixels SHALL output 24'h000000; all other behaviour identical.

Verification
REQ-030 Reset then run 2 frames -> first frame_start 2 clk after rst release; frame_start period 840000 clk; vga_clk period 2 clk.
REQ-031 Count h_sync low per line -> 96 pixel periods (192 clk), falling 656 pixel periods after rgb of h=0; v_sync low exactly 2 lines (1600 pixel periods) per frame.
REQ-032 Memory model returning fb_rdata=addr -> rgb for pixel (3,2) = BASE_ADDR+203 (IMG_W=100); 10000 fb_rd_en strobes per frame; last fb_addr BASE_ADDR+9999.
REQ-033 fb_rdata=32'hAB123456 constant -> rgb=24'h123456 for in-image pixels, 24'h000000 at (100,0), (0,100), (700,10).
REQ-034 Assert rst for 1 clk at (h=320,v=50) -> fb_rd_en=0 and rgb=0 next clk; frame restarts at (0,0) with fb_addr=BASE_ADDR.
REQ-035 With VGA_BORDER_EN defined -> rgb=24'hFFFFFF at (100,0), (100,100), (0,100); 24'h000000 at (101,0); undefined -> all three 24'h000000.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA raster generator that fetches an IMG_W x IMG_H
// image from a word-addressed frame buffer and drives RGB plus syncs.
//
// Ports:
//   clk          50 MHz system clock; the pixel rate is every other edge
//   rst          synchronous active-high reset
//   fb_rd_en     one-clk read strobe, issued on pixel edges only
//   fb_addr      frame-buffer word address for the current strobe
//   fb_rdata     read data, valid one clk after fb_rd_en; [23:0] = {R,G,B}
//   rgb          pixel colour to DAC
//   h_sync       horizontal sync, active low, aligned with rgb
//   v_sync       vertical sync, active low, aligned with rgb
//   vga_clk      25 MHz pixel clock (the phase bit)
//   frame_start  one-clk pulse after pixel (0,0) is launched
//
// Optional feature: define VGA_BORDER_EN to draw a white one-pixel frame just
// right of and below the image (h==IMG_W / v==IMG_H) inside the visible area.
`timescale 1ns/1ps
module vga_scanout #(
  parameter int          IMG_W     = 100,
  parameter int          IMG_H     = 100,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          S         = 32
) (
  input  logic          clk,
  input  logic          rst,
  output logic          fb_rd_en,
  output logic [S-1:0]  fb_addr,
  input  logic [S-1:0]  fb_rdata,
  output logic [23:0]   rgb,
  output logic          h_sync,
  output logic          v_sync,
  output logic          vga_clk,
  output logic          frame_start
);

  localparam logic [9:0]   IMG_W_L = 10'(IMG_W);
  localparam logic [9:0]   IMG_H_L = 10'(IMG_H);
  localparam logic [S-1:0] BASE_L  = S'(BASE_ADDR);
`ifdef VGA_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  function automatic logic in_image(input logic [9:0] h, input logic [9:0] v);
    return (h < IMG_W_L) && (v < IMG_H_L);
  endfunction

  // Border cells sit one pixel outside the image; clipped to the visible area
  // so a full-width or full-height image simply has no border on that side.
  function automatic logic on_border(input logic [9:0] h, input logic [9:0] v);
    return BORDER_EN && (h < 10'd640) && (v < 10'd480) &&
           (((h == IMG_W_L) && (v <= IMG_H_L)) || ((v == IMG_H_L) && (h <= IMG_W_L)));
  endfunction

  // Upper data bits carry no colour information.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^fb_rdata[S-1:24];

  logic          ph_q, ph_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [S-1:0]  addr_q, addr_d;
  logic          fb_rd_en_q, fb_rd_en_d;
  logic [S-1:0]  fb_addr_q, fb_addr_d;
  logic          frame_start_q, frame_start_d;
  logic          vld_p0, vld_p0_d;
  logic          bord_p0, bord_p0_d;
  logic          hs_p0, hs_p0_d;
  logic          vs_p0, vs_p0_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          in_img, first_px;

  always_comb begin
    in_img        = in_image(h_q, v_q);
    first_px      = (h_q == 10'd0) && (v_q == 10'd0);
    ph_d          = ~ph_q;
    h_d           = h_q;
    v_d           = v_q;
    addr_d        = addr_q;
    fb_rd_en_d    = 1'b0;
    fb_addr_d     = fb_addr_q;
    frame_start_d = 1'b0;
    vld_p0_d      = vld_p0;
    bord_p0_d     = bord_p0;
    hs_p0_d       = hs_p0;
    vs_p0_d       = vs_p0;
    rgb_d         = rgb_q;
    h_sync_d      = h_sync_q;
    v_sync_d      = v_sync_q;
    if (ph_q) begin
      // Stage p0: launch pixel (h,v) -- issue the read and capture its attributes.
      fb_rd_en_d    = in_img;
      frame_start_d = first_px;
      if (first_px) begin
        fb_addr_d = BASE_L;
        addr_d    = BASE_L + S'(1);
      end else if (in_img) begin
        fb_addr_d = addr_q;
        addr_d    = addr_q + S'(1);
      end
      vld_p0_d  = in_img;
      bord_p0_d = on_border(h_q, v_q);
      hs_p0_d   = !((h_q >= 10'd656) && (h_q <= 10'd751));
      vs_p0_d   = !((v_q >= 10'd490) && (v_q <= 10'd491));
      if (h_q == 10'd799) begin
        h_d = 10'd0;
        v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // Stage p1: present the previously launched pixel with its syncs.
      if (vld_p0)       rgb_d = fb_rdata[23:0];
      else if (bord_p0) rgb_d = 24'hFFFFFF;
      else              rgb_d = 24'h000000;
      h_sync_d = hs_p0;
      v_sync_d = vs_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q          <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      addr_q        <= BASE_L;
      fb_rd_en_q    <= 1'b0;
      fb_addr_q     <= '0;
      frame_start_q <= 1'b0;
      vld_p0        <= 1'b0;
      bord_p0       <= 1'b0;
      hs_p0         <= 1'b1;
      vs_p0         <= 1'b1;
      rgb_q         <= '0;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
    end else begin
      ph_q          <= ph_d;
      h_q           <= h_d;
      v_q           <= v_d;
      addr_q        <= addr_d;
      fb_rd_en_q    <= fb_rd_en_d;
      fb_addr_q     <= fb_addr_d;
      frame_start_q <= frame_start_d;
      vld_p0        <= vld_p0_d;
      bord_p0       <= bord_p0_d;
      hs_p0         <= hs_p0_d;
      vs_p0         <= vs_p0_d;
      rgb_q         <= rgb_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
    end
  end

  assign fb_rd_en    = fb_rd_en_q;
  assign fb_addr     = fb_addr_q;
  assign frame_start = frame_start_q;
  assign rgb         = rgb_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign vga_clk     = ph_q;

endmodule
